// File: rtl/bios_rom_port_arbiter.sv
// Arbitrates NUM_REQ valid/ready requesters onto one 1-cycle-latency BIOS ROM read port.
// Define BIOS_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module bios_rom_port_arbiter #(
  parameter int unsigned NUM_REQ   = 3,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                     clk_i,
  input  logic                     reset_ni,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic [NUM_REQ-1:0][31:0] req_addr_i,
  output logic [NUM_REQ-1:0]       rsp_valid_o,
  input  logic [NUM_REQ-1:0]       rsp_ready_i,
  output logic [31:0]              rsp_data_o,
  output logic                     rsp_err_o,
  output logic [31:0]              rom_addr_o,
  input  logic [31:0]              rom_data_i
);

  localparam int unsigned IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RESP_ROM  = 2'd1,
    RESP_HOLD = 2'd2,
    RESP_ERR  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  owner_q;
  logic [IDW-1:0]  winner;
  logic [31:0]     hold_q;
  logic            hold_load;
  logic            owner_ready;
  logic            grant_ok;
  logic            accept;
  logic            addr_ok;

  // Winner selection
`ifdef BIOS_ARB_ROUND_ROBIN_EN
  logic [IDW-1:0] rr_ptr_q;
  logic [IDW-1:0] cand;
  logic           found;

  always_comb begin
    winner = '0;
    cand   = '0;
    found  = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IDW'((32'(rr_ptr_q) + k) % NUM_REQ);
      if (!found && req_valid_i[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      rr_ptr_q <= IDW'(NUM_REQ - 1);
    end else if (accept) begin
      rr_ptr_q <= winner;
    end
  end
`else
  always_comb begin
    winner = '0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (req_valid_i[IDW'(i)]) winner = IDW'(i);
    end
  end
`endif

  // Reset gates the handshakes so nothing is accepted or delivered while it is low
  assign owner_ready = rsp_ready_i[owner_q];
  assign grant_ok    = reset_ni && ((state_q == IDLE) || owner_ready);
  assign accept      = grant_ok && (|req_valid_i);
  assign addr_ok     = (req_addr_i[winner][31:12] == BASE_ADDR[31:12]) &&
                       (req_addr_i[winner][1:0] == 2'b00);

  // Next state and outputs
  always_comb begin
    state_d     = state_q;
    hold_load   = 1'b0;
    req_ready_o = '0;
    rom_addr_o  = '0;
    rsp_valid_o = '0;
    rsp_data_o  = '0;
    rsp_err_o   = 1'b0;

    if (accept) begin
      req_ready_o[winner] = 1'b1;
      rom_addr_o          = req_addr_i[winner];
      state_d             = addr_ok ? RESP_ROM : RESP_ERR;
    end else if ((state_q != IDLE) && owner_ready) begin
      state_d = IDLE;
    end else if (state_q == RESP_ROM) begin
      state_d   = RESP_HOLD;
      hold_load = 1'b1;
    end

    if (reset_ni) begin
      case (state_q)
        RESP_ROM: begin
          rsp_valid_o[owner_q] = 1'b1;
          rsp_data_o           = rom_data_i;
        end
        RESP_HOLD: begin
          rsp_valid_o[owner_q] = 1'b1;
          rsp_data_o           = hold_q;
        end
        RESP_ERR: begin
          rsp_valid_o[owner_q] = 1'b1;
          rsp_err_o            = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      owner_q <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept)    owner_q <= winner;
      if (hold_load) hold_q  <= rom_data_i;
    end
  end

endmodule

// File: tb/tb_bios_rom_port_arbiter.sv
// Directed scoreboard bench for bios_rom_port_arbiter; follows BIOS_ARB_ROUND_ROBIN_EN for contention expectations.
module tb_bios_rom_port_arbiter;

  logic             clk;
  logic             reset_n;
  logic [2:0]       req_valid;
  logic [2:0]       req_ready;
  logic [2:0][31:0] req_addr;
  logic [2:0]       rsp_valid;
  logic [2:0]       rsp_ready;
  logic [31:0]      rsp_data;
  logic             rsp_err;
  logic [31:0]      rom_addr;
  logic [31:0]      rom_data;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int unsigned id;
  } exp_t;

  exp_t sb[$];

  bios_rom_port_arbiter #(
    .NUM_REQ  (3),
    .BASE_ADDR(32'h0000_0000)
  ) dut (
    .clk_i      (clk),
    .reset_ni   (reset_n),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .req_addr_i (req_addr),
    .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready),
    .rsp_data_o (rsp_data),
    .rsp_err_o  (rsp_err),
    .rom_addr_o (rom_addr),
    .rom_data_i (rom_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    if (a[11:2] == 10'd4) return 32'hDEAD_BEEF;
    return {12'hB10, a[11:0], 8'h5A};
  endfunction

  function automatic logic addr_ok(input logic [31:0] a);
    return (a[31:12] == 20'h0) && (a[1:0] == 2'b00);
  endfunction

  // ROM model: registered read, word valid one cycle after the address
  always @(posedge clk) rom_data <= rom_word(rom_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic mon();
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      if (rsp_valid[i] && rsp_ready[i]) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_rsp", 32'(i), 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          chk("sb_id", 32'(i), 32'(e.id));
          chk("sb_data", rsp_data, e.data);
          chk("sb_err", 32'(rsp_err), 32'(e.err));
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        e.id   = i;
        e.err  = !addr_ok(req_addr[i]);
        e.data = e.err ? 32'h0 : rom_word(req_addr[i]);
        sb.push_back(e);
      end
    end
  endtask

  task automatic smp();
    @(negedge clk);
    mon();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 8 && sb.size() != 0; k++) begin
      smp();
      adv();
    end
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0] exp_gnt;

    // Reset with requests pending: nothing granted, all outputs zero
    reset_n   = 1'b0;
    req_valid = 3'b111;
    req_addr  = {32'h48, 32'h44, 32'h40};
    rsp_ready = 3'b111;
    adv();
    adv();
    smp();
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rom_addr", rom_addr, 32'd0);
    adv();
    reset_n   = 1'b1;
    req_valid = 3'b000;

    // Single request from requester 1
    req_valid   = 3'b010;
    req_addr[1] = 32'h0000_0010;
    smp();
    chk("single_ready", 32'(req_ready), 32'b010);
    chk("single_rom_addr", rom_addr, 32'h10);
    adv();
    req_valid = 3'b000;
    smp();
    chk("single_valid", 32'(rsp_valid), 32'b010);
    chk("single_data", rsp_data, 32'hDEAD_BEEF);
    chk("single_err", 32'(rsp_err), 32'd0);
    adv();

    // Back-pressure on requester 0 with requester 1 waiting
    req_valid   = 3'b001;
    req_addr[0] = 32'h0000_0008;
    smp();
    chk("bp_accept", 32'(req_ready), 32'b001);
    adv();
    rsp_ready   = 3'b000;
    req_valid   = 3'b010;
    req_addr[1] = 32'h0000_0020;
    for (int k = 0; k < 3; k++) begin
      smp();
      chk("bp_valid", 32'(rsp_valid), 32'b001);
      chk("bp_data", rsp_data, rom_word(32'h8));
      chk("bp_no_accept", 32'(req_ready), 32'd0);
      adv();
    end
    rsp_ready = 3'b111;
    smp();
    chk("bp_valid_last", 32'(rsp_valid), 32'b001);
    chk("bp_data_last", rsp_data, rom_word(32'h8));
    chk("bp_pipelined_accept", 32'(req_ready), 32'b010);
    adv();
    req_valid = 3'b000;
    smp();
    chk("bp_next_valid", 32'(rsp_valid), 32'b010);
    adv();

    // Error responses: out of window, then misaligned
    req_valid   = 3'b100;
    req_addr[2] = 32'h0000_1000;
    smp();
    chk("err_accept", 32'(req_ready), 32'b100);
    adv();
    req_valid   = 3'b010;
    req_addr[1] = 32'h0000_0002;
    smp();
    chk("err_win_valid", 32'(rsp_valid), 32'b100);
    chk("err_win_data", rsp_data, 32'h0);
    chk("err_win_err", 32'(rsp_err), 32'd1);
    chk("err_align_accept", 32'(req_ready), 32'b010);
    adv();
    req_valid = 3'b000;
    smp();
    chk("err_align_valid", 32'(rsp_valid), 32'b010);
    chk("err_align_data", rsp_data, 32'h0);
    chk("err_align_err", 32'(rsp_err), 32'd1);
    adv();
    drain();

    // Fresh reset so arbitration starts from its reset pointer
    reset_n = 1'b0;
    smp();
    adv();
    reset_n = 1'b1;

    // Contention: all three requesting continuously
    req_valid = 3'b111;
    req_addr  = {32'h48, 32'h44, 32'h40};
    for (int k = 0; k < 6; k++) begin
`ifdef BIOS_ARB_ROUND_ROBIN_EN
      exp_gnt = 3'b001 << (k % 3);
`else
      exp_gnt = 3'b001;
`endif
      smp();
      chk("contention_grant", 32'(req_ready), 32'(exp_gnt));
      adv();
    end
    req_valid = 3'b000;
    drain();

    // Pipelined sequential reads from requester 0
    req_valid = 3'b001;
    for (int k = 0; k < 4; k++) begin
      req_addr[0] = 32'h100 + 32'(4 * k);
      smp();
      chk("pipe_accept", 32'(req_ready), 32'b001);
      if (k > 0) chk("pipe_valid", 32'(rsp_valid), 32'b001);
      adv();
    end
    req_valid = 3'b000;
    smp();
    chk("pipe_valid_last", 32'(rsp_valid), 32'b001);
    adv();
    drain();

    // Reset while a response is held
    req_valid   = 3'b001;
    req_addr[0] = 32'h0000_000C;
    smp();
    chk("rh_accept", 32'(req_ready), 32'b001);
    adv();
    rsp_ready   = 3'b000;
    req_valid   = 3'b010;
    req_addr[1] = 32'h0000_0024;
    smp();
    adv();
    smp();
    chk("rh_hold_valid", 32'(rsp_valid), 32'b001);
    chk("rh_hold_data", rsp_data, rom_word(32'hC));
    adv();
    reset_n = 1'b0;
    smp();
    chk("rh_rst_no_accept", 32'(req_ready), 32'd0);
    chk("rh_rst_no_valid", 32'(rsp_valid), 32'd0);
    adv();
    smp();
    chk("rh_post_ready", 32'(req_ready), 32'd0);
    chk("rh_post_valid", 32'(rsp_valid), 32'd0);
    chk("rh_post_data", rsp_data, 32'd0);
    chk("rh_post_err", 32'(rsp_err), 32'd0);
    chk("rh_post_rom_addr", rom_addr, 32'd0);
    sb.delete();
    adv();
    reset_n     = 1'b1;
    rsp_ready   = 3'b111;
    req_valid   = 3'b011;
    req_addr[0] = 32'h0000_0030;
    smp();
    chk("rh_first_grant", 32'(req_ready), 32'b001);
    adv();
    req_valid = 3'b000;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bios_rom_port_arbiter.md
# bios_rom_port_arbiter

Shares one 1-cycle-latency read port of the BIOS ROM between `NUM_REQ` requesters (e.g. CPU data-load path, debug reader, boot copier) using a valid/ready request channel and a valid/ready response channel per requester. It sits between the requesters and the ROM's second read port; the instruction-fetch port stays directly connected. The block arbitrates, range- and alignment-checks addresses, routes the ROM word back to the winner, and holds it under response back-pressure.

## Interface
Parameters:
- `NUM_REQ`, 3: number of requesters, 2..8.
- `BASE_ADDR`, 32'h0000_0000: 4 KiB-aligned base of the ROM window.

Ports:
- `clk_i`  in  1  single clock; all logic on its rising edge.
- `reset_ni`  in  1  reset, synchronous, active-low.
- `req_valid_i`  in  NUM_REQ  per-requester request valid.
- `req_ready_o`  out  NUM_REQ  per-requester request accept; at most one bit high.
- `req_addr_i`  in  NUM_REQ×32  per-requester byte address.
- `rsp_valid_o`  out  NUM_REQ  response valid, one-hot to the owning requester.
- `rsp_ready_i`  in  NUM_REQ  per-requester response accept.
- `rsp_data_o`  out  32  response word, shared; qualified by `rsp_valid_o`.
- `rsp_err_o`  out  1  response error flag, qualified by `rsp_valid_o`.
- `rom_addr_o`  out  32  to the ROM read-port address.
- `rom_data_i`  in  32  from the ROM read-port data (valid one cycle after address sampled).

## Operation
- Address check: OK iff `addr[31:12]==BASE_ADDR[31:12]` and `addr[1:0]==2'b00`; otherwise error.
- FSM states: IDLE, RESP_ROM, RESP_HOLD, RESP_ERR. Registers: owner id, hold data, RR pointer.
- Grant allowed when state is IDLE, or state is RESP_* and `rsp_ready_i[owner]` is high this cycle (pipelined back-to-back).
- When grant allowed and any `req_valid_i` set, winner's `req_ready_o` is high; handshake captures owner id.
- Accepted OK request: `rom_addr_o` = winner address that cycle; next state RESP_ROM. Accepted error request: ROM not relied on; next state RESP_ERR.
- No new accept while a response completes: next state IDLE.
- RESP_ROM: `rsp_valid_o[owner]`=1, `rsp_data_o`=`rom_data_i`, `rsp_err_o`=0. If `rsp_ready_i[owner]`=0, latch `rom_data_i` into hold, go RESP_HOLD.
- RESP_HOLD: present hold data, err=0, until accepted.
- RESP_ERR: present data 32'h0, err=1, until accepted.
- `rom_addr_o` = winner address when a grant is offered, else 32'h0.
- `req_ready_o` depends combinationally on `rsp_ready_i[owner]`; requesters must not make `rsp_ready_i` depend on `req_ready_o`.
- Reset mid-operation: outstanding response discarded without handshake; pending request not accepted.

## Timing
- Reset values: `req_ready_o`=0, `rsp_valid_o`=0, `rsp_data_o`=0, `rsp_err_o`=0, `rom_addr_o`=0, state IDLE, RR pointer=`NUM_REQ-1` (requester 0 first).
- Latency: accept at cycle N → `rsp_valid_o` in cycle N+1 (OK or error).
- Throughput: one response per cycle with continuous `rsp_ready_i`.
- Response data/err stable while `rsp_valid_o` high and not accepted.
- Requester must hold `req_addr_i` stable while `req_valid_i` high and not accepted.

## Configuration
- `BIOS_ARB_ROUND_ROBIN_EN` defined: round-robin; search starts at pointer+1 modulo `NUM_REQ`; pointer updates to winner on each accept only.
- Undefined: fixed priority, lowest index wins; RR pointer not built.

## Test plan
- Single request: req 1 addr 32'h0000_0010, ROM word 4 = 32'hDEAD_BEEF, ready held → `rsp_valid_o`=3'b010 cycle after accept, data 32'hDEAD_BEEF, err 0.
- Back-pressure: req 0 addr 32'h0000_0008, `rsp_ready_i` low 3 cycles → valid and data constant 4 cycles, state RESP_HOLD, no new accept.
- Error: req 2 addr 32'h0000_1000 and a separate request addr 32'h0000_0002 → each gets data 32'h0, err 1, one cycle after accept.
- Contention, RR enabled: all three valid continuously → grants 0,1,2,0,1,2 on consecutive cycles; disabled → 0 always.
- Pipelining: req 0 four sequential addrs, `rsp_ready_i` high → four responses in four consecutive cycles, correct words.
- Reset: `reset_ni` low during RESP_HOLD → next cycle all outputs 0, IDLE; first grant after release goes to req 0.
